opcode_fetch_unit: RTL and testbench
====================================

Name: opcode_fetch_unit

Overview:
Instruction-fetch front end. It pairs a byte-wide, dual-port simple MMU/memory with an opcode buffer. The buffer assembles a 32-bit opcode from four byte reads on the MMU's read-only port B. Port A of the MMU is exposed for loader/debug byte reads and writes.

Parameters:
MEM_BYTES, 1024, memory size in bytes (power of two); byte index = addr mod MEM_BYTES
LATENCY, 2, MMU busy-cycles per access (≥1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
addrA  in  32  port A byte address
writeEnable  in  1  port A: 1=write dataIn, 0=read
dataIn  in  8  port A write data
requestA  in  1  port A access request
outA  out  8  port A read data
busyA  out  1  port A access in progress
ip  in  32  opcode fetch address (byte address, any alignment)
startLoading  in  1  level request to make opcode at ip available
busy  out  1  opcode fetch in progress
opcode  out  32  assembled opcode, little-endian: byte ip → [7:0], ip+3 → [31:24]

Behaviour:
- Reset (reset==0 at a rising edge): all FSMs go to IDLE; busy, busyA, outA, opcode are 0; cached-valid is cleared. Memory contents are not cleared. Reset mid-access aborts the access. A pending write is dropped.
- MMU port FSM, per port, independent: IDLE → WAIT → IDLE.
  - A request sampled in cycle t while IDLE raises busy from t+1 through t+LATENCY.
  - busy is 0 at t+LATENCY+1, with out valid and held until the next completed read.
  - Requests while busy are ignored.
  - A write commits at completion; outA is unchanged on a write.
- Same-byte collision: a port A write completing in the same cycle as a port B read completing → port B returns the old byte.
- Opcode buffer FSM states: IDLE, REQ, WAIT_HI, WAIT_LO, DONE.
- IDLE: start condition is startLoading==1 and (!valid or ip != cachedIp).
  - On start: capture ip into cachedIp, byte index=0, busy=1 next cycle.
  - startLoading==1 with valid and ip==cachedIp is a hit: no memory traffic, busy stays 0.
- REQ: requestB=1 for exactly one cycle, addrB = cachedIp + index (mod 2^32).
- WAIT_HI: wait for busyB==1.
- WAIT_LO: wait for busyB==0, then latch outB into the opcode byte lane [index].
  - index<3 → increment index, go to REQ.
  - Else → DONE.
- DONE: set valid, busy=0 in the same cycle opcode becomes final, return to IDLE.
- opcode holds its value until the next fetch completes. During a fetch, opcode is undefined for checking; only valid once busy falls.
- ip changes during a fetch are ignored. Once the fetch finishes, a differing ip with startLoading high starts a new fetch.
- startLoading dropping mid-fetch does not abort the fetch.
- Fetch latency bound: busy high ≤ 4×(LATENCY+3)+2 cycles.
- requestB is 0 outside REQ. addrB is held stable through each access.

Decomposition:
- Shared package: MEM_BYTES/LATENCY defaults and the opcode-buffer state encoding.
- Sub-module byte_mmu: dual-port memory plus the two port FSMs.
- The opcode buffer FSM lives in opcode_fetch_unit and drives the byte_mmu port B wiring internally.

Test Plan:
- Preload bytes 0x00..0x0B at addresses 0..11 via port A writes (busyA pulses LATENCY cycles each). Then ip=0, startLoading=1 → busy falls, opcode=0x03020100.
- ip=4, then ip=8, startLoading held high → opcode=0x07060504, then 0x0B0A0908; each fetch issues exactly 4 requestB pulses at ip..ip+3.
- Hold ip=8 after completion → no requestB, busy stays 0, opcode unchanged. Unaligned ip=2 → opcode=0x05040302.
- Port A read of address 5 after preload → outA=0x05 when busyA falls. Write 0xAA to 5, refetch ip=4 → opcode=0x0706AA04.
- Assert reset (0) during WAIT_LO of byte 2 → next cycle busy=0, opcode=0, busyA=0. Release, same ip with startLoading → full refetch (cache invalidated).
- Address wrap: ip=MEM_BYTES-2 → bytes at MEM_BYTES-2, MEM_BYTES-1, 0, 1 assembled in order.

Source files
------------

// File: rtl/opcode_fetch_unit_pkg.sv
// Shared defaults and state encodings for the opcode fetch front end.
package opcode_fetch_unit_pkg;

  localparam int MEM_BYTES_DEFAULT = 1024;
  localparam int LATENCY_DEFAULT   = 2;

  typedef enum logic [2:0] {
    OB_IDLE    = 3'd0,
    OB_REQ     = 3'd1,
    OB_WAIT_HI = 3'd2,
    OB_WAIT_LO = 3'd3,
    OB_DONE    = 3'd4
  } ob_state_t;

  typedef enum logic {
    PORT_IDLE = 1'b0,
    PORT_WAIT = 1'b1
  } port_state_t;

  // Byte address of lane `lane` of an opcode starting at `base` (wraps at 2^32).
  function automatic logic [31:0] lane_addr(input logic [31:0] base, input logic [1:0] lane);
    return base + {30'd0, lane};
  endfunction

endpackage

// File: rtl/opcode_fetch_unit_byte_mmu.sv
// Byte-wide dual-port memory: port A read/write, port B read-only, each with
// its own fixed-latency access FSM.
module byte_mmu
  import opcode_fetch_unit_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int LATENCY   = LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_a,
  input  logic        we_a,
  input  logic [7:0]  din_a,
  input  logic        req_a,
  output logic [7:0]  out_a,
  output logic        busy_a,
  input  logic [31:0] addr_b,
  input  logic        req_b,
  output logic [7:0]  out_b,
  output logic        busy_b
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [7:0] mem [MEM_BYTES];

  port_state_t   state_a, state_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic [AW-1:0] idx_a, idx_b;
  logic          we_lat;
  logic [7:0]    din_lat;
  logic          done_a;

  assign done_a = (state_a == PORT_WAIT) && (cnt_a == '0);

  // Address is taken modulo MEM_BYTES; the full word feeds the reduction.
  function automatic logic [AW-1:0] to_index(input logic [31:0] addr);
    logic [31:0] m;
    m = addr % 32'(MEM_BYTES);
    return m[AW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_a <= PORT_IDLE;
      cnt_a   <= '0;
      idx_a   <= '0;
      we_lat  <= 1'b0;
      din_lat <= '0;
      busy_a  <= 1'b0;
      out_a   <= '0;
    end else begin
      case (state_a)
        PORT_IDLE: begin
          if (req_a) begin
            state_a <= PORT_WAIT;
            busy_a  <= 1'b1;
            cnt_a   <= CW'(LATENCY - 1);
            idx_a   <= to_index(addr_a);
            we_lat  <= we_a;
            din_lat <= din_a;
          end
        end
        PORT_WAIT: begin
          if (cnt_a == '0) begin
            state_a <= PORT_IDLE;
            busy_a  <= 1'b0;
            if (!we_lat) out_a <= mem[idx_a];
          end else begin
            cnt_a <= cnt_a - CW'(1);
          end
        end
        default: state_a <= PORT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_b <= PORT_IDLE;
      cnt_b   <= '0;
      idx_b   <= '0;
      busy_b  <= 1'b0;
      out_b   <= '0;
    end else begin
      case (state_b)
        PORT_IDLE: begin
          if (req_b) begin
            state_b <= PORT_WAIT;
            busy_b  <= 1'b1;
            cnt_b   <= CW'(LATENCY - 1);
            idx_b   <= to_index(addr_b);
          end
        end
        PORT_WAIT: begin
          if (cnt_b == '0) begin
            state_b <= PORT_IDLE;
            busy_b  <= 1'b0;
            // Non-blocking read: a same-edge port A write is not yet visible.
            out_b   <= mem[idx_b];
          end else begin
            cnt_b <= cnt_b - CW'(1);
          end
        end
        default: state_b <= PORT_IDLE;
      endcase
    end
  end

  // Contents survive reset; a write still in flight at reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && done_a && we_lat) mem[idx_a] <= din_lat;
  end

endmodule

// File: rtl/opcode_fetch_unit.sv
// Opcode buffer: assembles a little-endian 32-bit opcode from four byte reads
// on the MMU read port, caching the last fetched address.
module opcode_fetch_unit
  import opcode_fetch_unit_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int LATENCY   = LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addrA,
  input  logic        writeEnable,
  input  logic [7:0]  dataIn,
  input  logic        requestA,
  output logic [7:0]  outA,
  output logic        busyA,
  input  logic [31:0] ip,
  input  logic        startLoading,
  output logic        busy,
  output logic [31:0] opcode
);

  ob_state_t   state;
  logic        valid;
  logic [31:0] cached_ip;
  logic [1:0]  index;
  logic        req_b;
  logic [31:0] addr_b;
  logic [7:0]  out_b;
  logic        busy_b;

  byte_mmu #(
    .MEM_BYTES(MEM_BYTES),
    .LATENCY  (LATENCY)
  ) u_mmu (
    .clk   (clk),
    .reset (reset),
    .addr_a(addrA),
    .we_a  (writeEnable),
    .din_a (dataIn),
    .req_a (requestA),
    .out_a (outA),
    .busy_a(busyA),
    .addr_b(addr_b),
    .req_b (req_b),
    .out_b (out_b),
    .busy_b(busy_b)
  );

  // req_b/addr_b are loaded on entry to OB_REQ so the request lasts one cycle
  // and the address stays put until the next byte is requested.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= OB_IDLE;
      valid     <= 1'b0;
      cached_ip <= '0;
      index     <= '0;
      req_b     <= 1'b0;
      addr_b    <= '0;
      busy      <= 1'b0;
      opcode    <= '0;
    end else begin
      case (state)
        OB_IDLE: begin
          if (startLoading && (!valid || ip != cached_ip)) begin
            cached_ip <= ip;
            index     <= 2'd0;
            busy      <= 1'b1;
            req_b     <= 1'b1;
            addr_b    <= ip;
            state     <= OB_REQ;
          end
        end
        OB_REQ: begin
          req_b <= 1'b0;
          state <= OB_WAIT_HI;
        end
        OB_WAIT_HI: begin
          if (busy_b) state <= OB_WAIT_LO;
        end
        OB_WAIT_LO: begin
          if (!busy_b) begin
            opcode[{index, 3'b000} +: 8] <= out_b;
            if (index != 2'd3) begin
              index  <= index + 2'd1;
              req_b  <= 1'b1;
              addr_b <= lane_addr(cached_ip, index + 2'd1);
              state  <= OB_REQ;
            end else begin
              busy  <= 1'b0;
              valid <= 1'b1;
              state <= OB_DONE;
            end
          end
        end
        OB_DONE: state <= OB_IDLE;
        default: state <= OB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opcode_fetch_unit.sv
// Directed plus randomized bench for opcode_fetch_unit against a byte-array
// memory model and a one-entry opcode cache model.
module tb_opcode_fetch_unit;

  localparam int MB    = 1024;
  localparam int LAT   = 2;
  localparam int BOUND = 4 * (LAT + 3) + 2;

  logic        clk;
  logic        reset;
  logic [31:0] addrA;
  logic        writeEnable;
  logic [7:0]  dataIn;
  logic        requestA;
  logic [7:0]  outA;
  logic        busyA;
  logic [31:0] ip;
  logic        startLoading;
  logic        busy;
  logic [31:0] opcode;

  opcode_fetch_unit #(.MEM_BYTES(MB), .LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .addrA       (addrA),
    .writeEnable (writeEnable),
    .dataIn      (dataIn),
    .requestA    (requestA),
    .outA        (outA),
    .busyA       (busyA),
    .ip          (ip),
    .startLoading(startLoading),
    .busy        (busy),
    .opcode      (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0]  mdl [MB];
  logic        m_valid;
  logic [31:0] m_cip;
  logic [31:0] m_op;
  logic [7:0]  m_outa;

  // Observed port B request addresses, one entry per request pulse
  logic [31:0] mon_q [$];
  always @(posedge clk) if (reset && dut.req_b) mon_q.push_back(dut.addr_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_op(input logic [31:0] a);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      t = a + 32'(k);
      r[8*k +: 8] = mdl[t % 32'(MB)];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic port_a(input logic [31:0] a, input logic we, input logic [7:0] d);
    int n;
    addrA = a; writeEnable = we; dataIn = d; requestA = 1'b1;
    step();
    requestA = 1'b0;
    check("busyA_rise", {31'd0, busyA}, 32'd1);
    n = 1;
    while (busyA === 1'b1 && n < 20) begin
      step();
      if (busyA === 1'b1) n++;
    end
    check("busyA_width", n, LAT);
    if (we) mdl[a % 32'(MB)] = d;
    else    m_outa = mdl[a % 32'(MB)];
    check(we ? "outA_after_write" : "outA_read", {24'd0, outA}, {24'd0, m_outa});
  endtask

  // disturb: after the fetch starts, drop startLoading and move ip elsewhere
  task automatic do_fetch(input logic [31:0] a, input bit disturb);
    int base, n;
    bit will;
    will = !m_valid || (a != m_cip);
    base = mon_q.size();
    ip = a; startLoading = 1'b1;
    if (will) begin
      n = 0;
      do begin step(); n++; end while (busy !== 1'b1 && n < 4);
      check("fetch_busy_rise", {31'd0, busy}, 32'd1);
      if (disturb) begin ip = $urandom(); startLoading = 1'b0; end
      n = 1;
      while (busy === 1'b1 && n <= BOUND + 2) begin
        step();
        if (busy === 1'b1) n++;
      end
      check("fetch_busy_fall", {31'd0, busy}, 32'd0);
      check("fetch_latency_ok", {31'd0, (n <= BOUND)}, 32'd1);
      m_valid = 1'b1; m_cip = a; m_op = exp_op(a);
      check("opcode", opcode, m_op);
      check("reqB_count", mon_q.size() - base, 4);
      for (int k = 0; k < 4; k++)
        if (mon_q.size() > base + k) check("reqB_addr", mon_q[base + k], a + 32'(k));
      if (disturb) ip = a;
    end else begin
      for (int k = 0; k < 3; k++) begin
        step();
        check("hit_busy_low", {31'd0, busy}, 32'd0);
      end
      check("hit_no_reqB", mon_q.size() - base, 0);
      check("hit_opcode", opcode, m_op);
    end
  endtask

  function automatic logic [31:0] rand_hi();
    return $urandom() & ~32'(MB - 1);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [31:0] a;
    reset = 1'b0; addrA = '0; writeEnable = 1'b0; dataIn = '0; requestA = 1'b0;
    ip = '0; startLoading = 1'b0;
    m_valid = 1'b0; m_cip = '0; m_op = '0; m_outa = '0;
    repeat (3) step();
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_busyA",  {31'd0, busyA}, 32'd0);
    check("rst_outA",   {24'd0, outA},  32'd0);
    check("rst_opcode", opcode,         32'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 12; i++) port_a(32'(i), 1'b1, 8'(i));
    do_fetch(32'd0, 1'b0);
    check("op_0", opcode, 32'h0302_0100);
    do_fetch(32'd4, 1'b0);
    check("op_4", opcode, 32'h0706_0504);
    do_fetch(32'd8, 1'b0);
    check("op_8", opcode, 32'h0B0A_0908);
    do_fetch(32'd8, 1'b0);
    do_fetch(32'd2, 1'b0);
    check("op_2", opcode, 32'h0504_0302);

    port_a(32'd5, 1'b0, 8'h00);
    check("outA_5", {24'd0, outA}, 32'h05);
    port_a(32'd5, 1'b1, 8'hAA);
    do_fetch(32'd4, 1'b1);
    check("op_4_aa", opcode, 32'h0706_AA04);

    // Reset during WAIT_LO of byte index 2, with a port A read in flight
    ip = 32'd0; startLoading = 1'b1;
    c0 = 0;
    do begin step(); c0++; end while (busy !== 1'b1 && c0 < 4);
    repeat (9) step();
    addrA = 32'd3; writeEnable = 1'b0; requestA = 1'b1;
    step();
    requestA = 1'b0;
    reset = 1'b0;
    step();
    check("midrst_busy",   {31'd0, busy},  32'd0);
    check("midrst_busyA",  {31'd0, busyA}, 32'd0);
    check("midrst_outA",   {24'd0, outA},  32'd0);
    check("midrst_opcode", opcode,         32'd0);
    reset = 1'b1;
    m_valid = 1'b0; m_op = '0; m_outa = '0;
    do_fetch(32'd0, 1'b0);
    check("op_0_after_rst", opcode, 32'h0302_0100);

    for (int i = 12; i < 16; i++) port_a(32'(i), 1'b1, 8'($urandom()));
    port_a(32'(MB - 4), 1'b1, 8'hC4);
    port_a(32'(MB - 3), 1'b1, 8'hC3);
    port_a(32'(MB - 2), 1'b1, 8'hE1);
    port_a(32'(MB - 1), 1'b1, 8'hE2);
    do_fetch(32'(MB - 2), 1'b0);
    check("op_wrap", opcode, {mdl[1], mdl[0], 8'hE2, 8'hE1});

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = rand_hi() | (($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15))
                                                       : 32'(MB - 4 + $urandom_range(0, 3)));
          port_a(a, 1'b1, 8'($urandom()));
        end
        1: begin
          a = rand_hi() | (($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15))
                                                       : 32'(MB - 4 + $urandom_range(0, 3)));
          port_a(a, 1'b0, 8'h00);
        end
        2: do_fetch(m_valid ? m_cip : 32'd0, 1'b0);
        default: begin
          a = rand_hi() | (($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 12))
                                                       : 32'(MB - 4 + $urandom_range(0, 3)));
          do_fetch(a, $urandom_range(0, 3) == 0);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
